// File: rtl/mult_8x8_seq_ctrl_if.sv
// Producer/consumer handshake bundle for the sequential 8x8 multiplier controller.
// The master side is the producer/consumer pair; the slave side is the controller.
interface mult_8x8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [3:0]  cfg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] R;
  logic        sat;

  modport master (
    output in_valid, A, B, cfg, out_ready,
    input  in_ready, out_valid, R, sat
  );

  modport slave (
    input  in_valid, A, B, cfg, out_ready,
    output in_ready, out_valid, R, sat
  );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// Builds an 8x8 product from one shared external 4x4 sub-multiplier, one quadrant per
// cycle, with optional skipping of zero-nibble quadrants and saturating accumulation.
module mult_8x8_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_8x8_seq_ctrl_if.slave   bus,
  output logic [3:0]           sub_a,
  output logic [3:0]           sub_b,
  output logic                 sub_sel,
  input  logic [7:0]           sub_r
);

  typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3, DONE} state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  a_l;
  logic [7:0]  b_l;
  logic [3:0]  cfg_l;
  logic [15:0] acc;
  logic        sat_r;
  logic [3:0]  act_l;
  logic [15:0] part;
  logic [16:0] sum;
  logic        accum;

  // Bit q set when quadrant q has to be computed for this operand pair.
  function automatic logic [3:0] active_q(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] act;
    act[0] = (a[3:0] != 4'h0) && (b[3:0] != 4'h0);
    act[1] = (a[3:0] != 4'h0) && (b[7:4] != 4'h0);
    act[2] = (a[7:4] != 4'h0) && (b[3:0] != 4'h0);
    act[3] = (a[7:4] != 4'h0) && (b[7:4] != 4'h0);
    return SKIP_ZERO ? act : 4'hF;
  endfunction

  function automatic state_t first_from(input logic [3:0] act, input logic [2:0] k);
    if (act[0] && (k == 3'd0))  return Q0;
    if (act[1] && (k <= 3'd1))  return Q1;
    if (act[2] && (k <= 3'd2))  return Q2;
    if (act[3] && (k <= 3'd3))  return Q3;
    return DONE;
  endfunction

  assign act_l = active_q(a_l, b_l);

  always_comb begin
    state_nx = state;
    sub_a    = 4'h0;
    sub_b    = 4'h0;
    sub_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) state_nx = first_from(active_q(bus.A, bus.B), 3'd0);
      end
      Q0: begin
        sub_a    = a_l[3:0];
        sub_b    = b_l[3:0];
        sub_sel  = cfg_l[0];
        state_nx = first_from(act_l, 3'd1);
      end
      Q1: begin
        sub_a    = a_l[3:0];
        sub_b    = b_l[7:4];
        sub_sel  = cfg_l[1];
        state_nx = first_from(act_l, 3'd2);
      end
      Q2: begin
        sub_a    = a_l[7:4];
        sub_b    = b_l[3:0];
        sub_sel  = cfg_l[2];
        state_nx = first_from(act_l, 3'd3);
      end
      Q3: begin
        sub_a    = a_l[7:4];
        sub_b    = b_l[7:4];
        sub_sel  = cfg_l[3];
        state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Kept apart from the sub_a/sub_b decode so the external sub_r path never looks like a loop.
  always_comb begin
    part  = 16'h0000;
    accum = 1'b0;
    case (state)
      Q0:      begin part = {8'h00, sub_r};        accum = 1'b1; end
      Q1, Q2:  begin part = {4'h0, sub_r, 4'h0};   accum = 1'b1; end
      Q3:      begin part = {sub_r, 8'h00};        accum = 1'b1; end
      default: begin part = 16'h0000;              accum = 1'b0; end
    endcase
  end

  assign sum = {1'b0, acc} + {1'b0, part};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_l   <= 8'h00;
      b_l   <= 8'h00;
      cfg_l <= 4'h0;
      acc   <= 16'h0000;
      sat_r <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && bus.in_valid) begin
        a_l   <= bus.A;
        b_l   <= bus.B;
        cfg_l <= bus.cfg;
        acc   <= 16'h0000;
        sat_r <= 1'b0;
      end else if (accum) begin
        // Once saturated the result is pinned at full scale for the rest of the operation.
        if (sum[16] || sat_r) begin
          acc   <= 16'hFFFF;
          sat_r <= 1'b1;
        end else begin
          acc   <= sum[15:0];
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.R         = acc;
  assign bus.sat       = sat_r;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Scoreboard bench for mult_8x8_seq_ctrl: dut0 always runs four quadrants, dut1 skips
// zero-nibble quadrants; a per-DUT monitor checks latency, result, sat and stall behaviour.
module tb_mult_8x8_seq_ctrl;

  typedef struct {
    logic [15:0] r;
    logic        sat;
    int          lat;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ff_mode;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [1:0]  in_valid_s;
  logic [1:0]  out_ready_s;
  logic [1:0]  in_ready_s;
  logic [1:0]  out_valid_s;
  logic [1:0]  sat_s;
  logic [1:0]  sub_sel_s;
  logic [1:0]  seen_valid;
  logic [7:0]  a_s [2];
  logic [7:0]  b_s [2];
  logic [3:0]  cfg_s [2];
  logic [15:0] r_s [2];
  logic [3:0]  sub_a_s [2];
  logic [3:0]  sub_b_s [2];
  logic [7:0]  sub_r_s [2];

  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_8x8_seq_ctrl_if bus0 ();
  mult_8x8_seq_ctrl_if bus1 ();

  assign bus0.in_valid  = in_valid_s[0];
  assign bus0.A         = a_s[0];
  assign bus0.B         = b_s[0];
  assign bus0.cfg       = cfg_s[0];
  assign bus0.out_ready = out_ready_s[0];
  assign in_ready_s[0]  = bus0.in_ready;
  assign out_valid_s[0] = bus0.out_valid;
  assign r_s[0]         = bus0.R;
  assign sat_s[0]       = bus0.sat;

  assign bus1.in_valid  = in_valid_s[1];
  assign bus1.A         = a_s[1];
  assign bus1.B         = b_s[1];
  assign bus1.cfg       = cfg_s[1];
  assign bus1.out_ready = out_ready_s[1];
  assign in_ready_s[1]  = bus1.in_ready;
  assign out_valid_s[1] = bus1.out_valid;
  assign r_s[1]         = bus1.R;
  assign sat_s[1]       = bus1.sat;

  // Exact 4x4 sub-multiplier, or a stuck-at-FF unit to force saturation.
  assign sub_r_s[0] = ff_mode ? 8'hFF : ({4'h0, sub_a_s[0]} * {4'h0, sub_b_s[0]});
  assign sub_r_s[1] = ff_mode ? 8'hFF : ({4'h0, sub_a_s[1]} * {4'h0, sub_b_s[1]});

  mult_8x8_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus0.slave),
    .sub_a   (sub_a_s[0]),
    .sub_b   (sub_b_s[0]),
    .sub_sel (sub_sel_s[0]),
    .sub_r   (sub_r_s[0])
  );

  mult_8x8_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus1.slave),
    .sub_a   (sub_a_s[1]),
    .sub_b   (sub_b_s[1]),
    .sub_sel (sub_sel_s[1]),
    .sub_r   (sub_r_s[1])
  );

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One monitor step per DUT: latency on first valid, then R/sat/in_ready every valid cycle.
  task automatic checkOutput(input int idx);
    exp_t e;
    int   depth;
    if (rst) begin
      seen_valid[idx] = 1'b0;
      return;
    end
    if (!out_valid_s[idx]) begin
      seen_valid[idx] = 1'b0;
      return;
    end
    depth = (idx == 0) ? q0.size() : q1.size();
    if (depth == 0) begin
      compare($sformatf("dut%0d unexpected out_valid", idx), 32'(out_valid_s[idx]), 32'h0);
      return;
    end
    e = (idx == 0) ? q0[0] : q1[0];
    if (!seen_valid[idx]) begin
      compare($sformatf("dut%0d latency", idx), 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
      seen_valid[idx] = 1'b1;
    end
    compare($sformatf("dut%0d R", idx), 32'(r_s[idx]), 32'(e.r));
    compare($sformatf("dut%0d sat", idx), 32'(sat_s[idx]), 32'(e.sat));
    compare($sformatf("dut%0d in_ready in DONE", idx), 32'(in_ready_s[idx]), 32'h0);
    if (out_ready_s[idx]) begin
      if (idx == 0) void'(q0.pop_front());
      else          void'(q1.pop_front());
      seen_valid[idx] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0);
    checkOutput(1);
  end

  // Handshake one operation; returns at the negedge after the accept edge.
  task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] cfg, input logic [15:0] er, input logic es,
                               input int el, input bit push);
    exp_t e;
    a_s[idx]        = a;
    b_s[idx]        = b;
    cfg_s[idx]      = cfg;
    in_valid_s[idx] = 1'b1;
    for (int i = 0; i < 50 && !in_ready_s[idx]; i++) @(negedge clk);
    compare($sformatf("dut%0d in_ready before accept", idx), 32'(in_ready_s[idx]), 32'h1);
    e.r       = er;
    e.sat     = es;
    e.lat     = el;
    e.acc_cyc = cyc + 1;
    if (push) begin
      if (idx == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_s[idx] = 1'b0;
  endtask

  task automatic waitDone(input int idx);
    int depth;
    depth = 1;
    for (int i = 0; i < 60 && depth != 0; i++) begin
      @(negedge clk);
      depth = (idx == 0) ? q0.size() : q1.size();
    end
    compare($sformatf("dut%0d pending results after timeout", idx), 32'(depth), 32'h0);
    if (idx == 0) q0.delete();
    else          q1.delete();
  endtask

  task automatic checkSub(input int idx, input string tag, input logic [3:0] ea,
                          input logic [3:0] eb, input logic es);
    compare($sformatf("dut%0d sub_a %s", idx, tag), 32'(sub_a_s[idx]), 32'(ea));
    compare($sformatf("dut%0d sub_b %s", idx, tag), 32'(sub_b_s[idx]), 32'(eb));
    compare($sformatf("dut%0d sub_sel %s", idx, tag), 32'(sub_sel_s[idx]), 32'(es));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    ff_mode     = 1'b0;
    in_valid_s  = 2'b00;
    out_ready_s = 2'b11;
    seen_valid  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a_s[i]   = 8'h00;
      b_s[i]   = 8'h00;
      cfg_s[i] = 4'h0;
    end
    $display("[TB] start");
    @(negedge clk);
    @(negedge clk);

    // Reset values on both instances.
    for (int i = 0; i < 2; i++) begin
      compare($sformatf("dut%0d reset in_ready", i), 32'(in_ready_s[i]), 32'h1);
      compare($sformatf("dut%0d reset out_valid", i), 32'(out_valid_s[i]), 32'h0);
      compare($sformatf("dut%0d reset R", i), 32'(r_s[i]), 32'h0);
      compare($sformatf("dut%0d reset sat", i), 32'(sat_s[i]), 32'h0);
      checkSub(i, "reset", 4'h0, 4'h0, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Full four-quadrant run, checking the nibble routing per quadrant.
    applyStimulus(0, 8'h12, 8'h34, 4'b0000, 16'h03A8, 1'b0, 5, 1'b1);
    checkSub(0, "Q0", 4'h2, 4'h4, 1'b0);
    @(negedge clk); checkSub(0, "Q1", 4'h2, 4'h3, 1'b0);
    @(negedge clk); checkSub(0, "Q2", 4'h1, 4'h4, 1'b0);
    @(negedge clk); checkSub(0, "Q3", 4'h1, 4'h3, 1'b0);
    waitDone(0);
    checkSub(0, "idle", 4'h0, 4'h0, 1'b0);

    // Per-quadrant variant select follows cfg.
    applyStimulus(0, 8'hFF, 8'hFF, 4'b1000, 16'hFE01, 1'b0, 5, 1'b1);
    checkSub(0, "cfg Q0", 4'hF, 4'hF, 1'b0);
    @(negedge clk); checkSub(0, "cfg Q1", 4'hF, 4'hF, 1'b0);
    @(negedge clk); checkSub(0, "cfg Q2", 4'hF, 4'hF, 1'b0);
    @(negedge clk); checkSub(0, "cfg Q3", 4'hF, 4'hF, 1'b1);
    waitDone(0);

    // Zero operands without skipping still take four quadrants.
    applyStimulus(0, 8'h00, 8'h00, 4'b0101, 16'h0000, 1'b0, 5, 1'b1);
    waitDone(0);

    // Saturation with a stuck sub-multiplier.
    ff_mode = 1'b1;
    applyStimulus(0, 8'hFF, 8'hFF, 4'b1111, 16'hFFFF, 1'b1, 5, 1'b1);
    waitDone(0);
    ff_mode = 1'b0;

    // Consumer stall: sat must be clear again, R held, new requests ignored.
    out_ready_s[0] = 1'b0;
    applyStimulus(0, 8'h02, 8'h03, 4'b0000, 16'h0006, 1'b0, 5, 1'b1);
    for (int i = 0; i < 20 && !out_valid_s[0]; i++) @(negedge clk);
    a_s[0]        = 8'hFF;
    b_s[0]        = 8'hFF;
    in_valid_s[0] = 1'b1;
    repeat (3) @(negedge clk);
    in_valid_s[0]  = 1'b0;
    out_ready_s[0] = 1'b1;
    waitDone(0);

    // Skip-zero instance: latency tracks the number of active quadrants.
    applyStimulus(1, 8'h0F, 8'h0F, 4'b0000, 16'h00E1, 1'b0, 2, 1'b1);
    checkSub(1, "only Q0", 4'hF, 4'hF, 1'b0);
    waitDone(1);
    applyStimulus(1, 8'h00, 8'h5A, 4'b1111, 16'h0000, 1'b0, 1, 1'b1);
    checkSub(1, "all skipped", 4'h0, 4'h0, 1'b0);
    waitDone(1);
    applyStimulus(1, 8'h12, 8'h34, 4'b0000, 16'h03A8, 1'b0, 5, 1'b1);
    waitDone(1);
    applyStimulus(1, 8'h01, 8'h10, 4'b0010, 16'h0010, 1'b0, 2, 1'b1);
    checkSub(1, "only Q1", 4'h1, 4'h1, 1'b1);
    waitDone(1);
    applyStimulus(1, 8'hF0, 8'h0F, 4'b0000, 16'h0E10, 1'b0, 2, 1'b1);
    checkSub(1, "only Q2", 4'hF, 4'hF, 1'b0);
    waitDone(1);
    applyStimulus(1, 8'h80, 8'h80, 4'b0000, 16'h4000, 1'b0, 2, 1'b1);
    checkSub(1, "only Q3", 4'h8, 4'h8, 1'b0);
    waitDone(1);

    // Reset in Q2 discards the operation; no result may ever appear.
    applyStimulus(0, 8'h12, 8'h34, 4'b0000, 16'h0000, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkSub(0, "Q2 before reset", 4'h1, 4'h4, 1'b0);
    rst = 1'b1;
    #1;
    compare("dut0 mid-op reset out_valid", 32'(out_valid_s[0]), 32'h0);
    compare("dut0 mid-op reset R", 32'(r_s[0]), 32'h0);
    compare("dut0 mid-op reset sat", 32'(sat_s[0]), 32'h0);
    compare("dut0 mid-op reset in_ready", 32'(in_ready_s[0]), 32'h1);
    checkSub(0, "mid-op reset", 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    compare("dut0 in_ready after reset", 32'(in_ready_s[0]), 32'h1);

    // Normal operation resumes after the discarded one.
    applyStimulus(0, 8'h0A, 8'h0B, 4'b0000, 16'h006E, 1'b0, 5, 1'b1);
    waitDone(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
